// File: rtl/vga_timing_pkg.sv
// Shared mode constants and helpers for the video timing generator.
// Covers 640x480@60 (default) and 800x600@60.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] visible;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } axis_mode_t;

    localparam int M640_H_VISIBLE = 640;
    localparam int M640_H_FRONT   = 16;
    localparam int M640_H_SYNC    = 96;
    localparam int M640_H_BACK    = 48;
    localparam int M640_V_VISIBLE = 480;
    localparam int M640_V_FRONT   = 10;
    localparam int M640_V_SYNC    = 2;
    localparam int M640_V_BACK    = 33;
    localparam bit M640_HS_POL    = 1'b0;
    localparam bit M640_VS_POL    = 1'b0;

    localparam int M800_H_VISIBLE = 800;
    localparam int M800_H_FRONT   = 40;
    localparam int M800_H_SYNC    = 128;
    localparam int M800_H_BACK    = 88;
    localparam int M800_V_VISIBLE = 600;
    localparam int M800_V_FRONT   = 1;
    localparam int M800_V_SYNC    = 4;
    localparam int M800_V_BACK    = 23;
    localparam bit M800_HS_POL    = 1'b1;
    localparam bit M800_VS_POL    = 1'b1;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // Linear pixel index (v*h_total+h) of the reset position advanced by n.
    function automatic int ahead_pos(input int h_total, input int v_total,
                                     input int n);
        int frame;
        frame = h_total * v_total;
        return (frame - 1 + (n % frame)) % frame;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered sync and
// visible flags derived from the next count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int LIMIT      = 800,
    parameter int VISIBLE    = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter bit POL        = 1'b0,
    parameter int RST_VAL    = 799
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             visible
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_VAL);
    localparam bit RST_IN_SYNC = (RST_VAL >= SYNC_START) &&
                                 (RST_VAL < SYNC_START + SYNC_LEN);
    localparam bit RST_SYNC = RST_IN_SYNC ? POL : !POL;
    localparam bit RST_VIS  = RST_VAL < VISIBLE;

    logic [CNT_W-1:0] nxt;
    logic             nxt_in_sync;
    logic             nxt_vis;

    assign wrap        = (count == LAST);
    assign nxt         = wrap ? '0 : count + 1'b1;
    assign nxt_in_sync = (int'(nxt) >= SYNC_START) &&
                         (int'(nxt) < SYNC_START + SYNC_LEN);
    assign nxt_vis     = int'(nxt) < VISIBLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= RST_CNT;
            sync    <= RST_SYNC;
            visible <= RST_VIS;
        end else if (step) begin
            count   <= nxt;
            sync    <= nxt_in_sync ^ ~POL;
            visible <= nxt_vis;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator advancing on a pixel clock-enable.
// Define VGA_TIMING_PREFETCH_EN to add the fetch_x/fetch_y/fetch_de lead outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = M640_H_VISIBLE,
    parameter int H_FRONT   = M640_H_FRONT,
    parameter int H_SYNC    = M640_H_SYNC,
    parameter int H_BACK    = M640_H_BACK,
    parameter int V_VISIBLE = M640_V_VISIBLE,
    parameter int V_FRONT   = M640_V_FRONT,
    parameter int V_SYNC    = M640_V_SYNC,
    parameter int V_BACK    = M640_V_BACK,
    parameter bit HS_POL    = M640_HS_POL,
    parameter bit VS_POL    = M640_VS_POL,
    parameter int CNT_W     = 12,
    parameter int FRAME_W   = 16,
    parameter int PREFETCH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    output logic [CNT_W-1:0]   hc,
    output logic [CNT_W-1:0]   vc,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
`ifdef VGA_TIMING_PREFETCH_EN
    output logic [CNT_W-1:0]   fetch_x,
    output logic [CNT_W-1:0]   fetch_y,
    output logic               fetch_de,
`endif
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    logic h_wrap;
    logic v_wrap;
    logic h_vis;
    logic v_vis;
    logic v_step;
    logic frame_wrap;
    logic primed;

    assign v_step     = pix_ce & h_wrap;
    assign frame_wrap = v_step & v_wrap;
    assign de         = h_vis & v_vis;

    vga_axis_counter #(
        .CNT_W(CNT_W), .LIMIT(H_TOTAL), .VISIBLE(H_VISIBLE),
        .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_LEN(H_SYNC),
        .POL(HS_POL), .RST_VAL(H_TOTAL - 1)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(pix_ce),
        .count(hc), .wrap(h_wrap), .sync(hsync), .visible(h_vis)
    );

    vga_axis_counter #(
        .CNT_W(CNT_W), .LIMIT(V_TOTAL), .VISIBLE(V_VISIBLE),
        .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_LEN(V_SYNC),
        .POL(VS_POL), .RST_VAL(V_TOTAL - 1)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(v_step),
        .count(vc), .wrap(v_wrap), .sync(vsync), .visible(v_vis)
    );

    // The wrap out of the reset position starts the first frame; it does
    // not complete one, so primed gates the first increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            primed      <= 1'b0;
        end else begin
            line_start  <= v_step;
            frame_start <= frame_wrap;
            if (pix_ce)
                primed <= 1'b1;
            if (frame_wrap && primed)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef VGA_TIMING_PREFETCH_EN
    localparam int F_IDX = ahead_pos(H_TOTAL, V_TOTAL, PREFETCH);
    localparam int F_H   = F_IDX % H_TOTAL;
    localparam int F_V   = F_IDX / H_TOTAL;

    logic fh_wrap;
    logic fv_wrap;
    logic fh_sync;
    logic fv_sync;
    logic fh_vis;
    logic fv_vis;
    logic unused_fetch;

    assign fetch_de     = fh_vis & fv_vis;
    assign unused_fetch = ^{fh_sync, fv_sync, fv_wrap};

    vga_axis_counter #(
        .CNT_W(CNT_W), .LIMIT(H_TOTAL), .VISIBLE(H_VISIBLE),
        .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_LEN(H_SYNC),
        .POL(HS_POL), .RST_VAL(F_H)
    ) u_fh (
        .clk(clk), .rst_n(rst_n), .step(pix_ce),
        .count(fetch_x), .wrap(fh_wrap), .sync(fh_sync), .visible(fh_vis)
    );

    vga_axis_counter #(
        .CNT_W(CNT_W), .LIMIT(V_TOTAL), .VISIBLE(V_VISIBLE),
        .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_LEN(V_SYNC),
        .POL(VS_POL), .RST_VAL(F_V)
    ) u_fv (
        .clk(clk), .rst_n(rst_n), .step(pix_ce & fh_wrap),
        .count(fetch_y), .wrap(fv_wrap), .sync(fv_sync), .visible(fv_vis)
    );
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-CE bench: three timing modes checked each cycle against a
// position-index model (pixel k after reset -> (hc,vc,...)).
module tb_vga_timing_gen;

    typedef struct {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int hp; int vp; int fw;
    } mode_t;

    typedef struct {
        int hc; int vc; int hs; int vs; int de; int fc;
    } exp_t;

    mode_t ma = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16};
    mode_t mb = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 1, 2};
    mode_t mc = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    logic [11:0] hc_a, vc_a, hc_c, vc_c;
    logic [3:0]  hc_b, vc_b;
    logic hs_a, vs_a, de_a, ls_a, fs_a;
    logic hs_b, vs_b, de_b, ls_b, fs_b;
    logic hs_c, vs_c, de_c, ls_c, fs_c;
    logic [15:0] fc_a, fc_c;
    logic [1:0]  fc_b;
`ifdef VGA_TIMING_PREFETCH_EN
    logic [11:0] fx_a, fy_a;
    logic        fde_a;
    logic [3:0]  fx_b, fy_b;
    logic        fde_b;
`endif

    int checks = 0;
    int passed = 0;
    longint k = 0;
    bit last_ce = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_ce(ce),
        .hc(hc_a), .vc(vc_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a),
`ifdef VGA_TIMING_PREFETCH_EN
        .fetch_x(fx_a), .fetch_y(fy_a), .fetch_de(fde_a),
`endif
        .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .FRAME_W(2), .PREFETCH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_ce(ce),
        .hc(hc_b), .vc(vc_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b),
`ifdef VGA_TIMING_PREFETCH_EN
        .fetch_x(fx_b), .fetch_y(fy_b), .fetch_de(fde_b),
`endif
        .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(vga_timing_pkg::M800_H_VISIBLE),
        .H_FRONT(vga_timing_pkg::M800_H_FRONT),
        .H_SYNC(vga_timing_pkg::M800_H_SYNC),
        .H_BACK(vga_timing_pkg::M800_H_BACK),
        .V_VISIBLE(vga_timing_pkg::M800_V_VISIBLE),
        .V_FRONT(vga_timing_pkg::M800_V_FRONT),
        .V_SYNC(vga_timing_pkg::M800_V_SYNC),
        .V_BACK(vga_timing_pkg::M800_V_BACK),
        .HS_POL(vga_timing_pkg::M800_HS_POL),
        .VS_POL(vga_timing_pkg::M800_VS_POL)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .pix_ce(ce),
        .hc(hc_c), .vc(vc_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
        .line_start(ls_c), .frame_start(fs_c),
`ifdef VGA_TIMING_PREFETCH_EN
        .fetch_x(), .fetch_y(), .fetch_de(),
`endif
        .frame_cnt(fc_c)
    );

    // Pixel k after reset sits at linear index k-1 of the frame sequence.
    function automatic exp_t model(input longint kk, input mode_t m);
        exp_t e;
        longint ht, vt, n, p;
        ht = m.hv + m.hf + m.hs + m.hb;
        vt = m.vv + m.vf + m.vs + m.vb;
        n  = ht * vt;
        p  = (kk == 0) ? n - 1 : (kk - 1) % n;
        e.hc = int'(p % ht);
        e.vc = int'(p / ht);
        e.hs = (e.hc >= m.hv + m.hf && e.hc < m.hv + m.hf + m.hs) ? m.hp : 1 - m.hp;
        e.vs = (e.vc >= m.vv + m.vf && e.vc < m.vv + m.vf + m.vs) ? m.vp : 1 - m.vp;
        e.de = (e.hc < m.hv && e.vc < m.vv) ? 1 : 0;
        e.fc = (kk == 0) ? 0 : int'(((kk - 1) / n) % (longint'(1) << m.fw));
        return e;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)",
                     nm, act, exp, k, $time);
    endtask

    task automatic cmp_dut(input string p, input mode_t m,
                           input int hc, input int vc, input int hs,
                           input int vs, input int de, input int ls,
                           input int fs, input int fc);
        exp_t e;
        e = model(k, m);
        cmp({p, "_hc"}, hc, e.hc);
        cmp({p, "_vc"}, vc, e.vc);
        cmp({p, "_hsync"}, hs, e.hs);
        cmp({p, "_vsync"}, vs, e.vs);
        cmp({p, "_de"}, de, e.de);
        cmp({p, "_line_start"}, ls, (last_ce && e.hc == 0) ? 1 : 0);
        cmp({p, "_frame_start"}, fs, (last_ce && e.hc == 0 && e.vc == 0) ? 1 : 0);
        cmp({p, "_frame_cnt"}, fc, e.fc);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            last_ce = 1'b0;
        end else begin
            last_ce = ce;
            if (ce) k = k + 1;
        end
    end

    always @(negedge clk) begin
        cmp_dut("a", ma, hc_a, vc_a, hs_a, vs_a, de_a, ls_a, fs_a, fc_a);
        cmp_dut("b", mb, hc_b, vc_b, hs_b, vs_b, de_b, ls_b, fs_b, fc_b);
        cmp_dut("c", mc, hc_c, vc_c, hs_c, vs_c, de_c, ls_c, fs_c, fc_c);
`ifdef VGA_TIMING_PREFETCH_EN
        begin
            exp_t fa, fb;
            fa = model(k + 2, ma);
            fb = model(k + 2, mb);
            cmp("a_fetch_x", fx_a, fa.hc);
            cmp("a_fetch_y", fy_a, fa.vc);
            cmp("a_fetch_de", fde_a, fa.de);
            cmp("b_fetch_x", fx_b, fb.hc);
            cmp("b_fetch_y", fy_b, fb.vc);
            cmp("b_fetch_de", fde_b, fb.de);
        end
`endif
        if (k == 656) cmp("a_hsync_655", hs_a, 1);
        if (k == 657) cmp("a_hsync_656", hs_a, 0);
        if (k == 752) cmp("a_hsync_751", hs_a, 0);
        if (k == 753) cmp("a_hsync_752", hs_a, 1);
        if (k == 801) cmp("a_line_vc", vc_a, 1);
        if (k == 16)  cmp("b_line_hc", hc_b, 0);
        if (k == 361) cmp("b_three_frames", fc_b, 3);
        if (k == 481) cmp("b_fc_wrap", fc_b, 0);
        if (k == 1057) cmp("c_line_period_hc", hc_c, 0);
        if (k == 1057) cmp("c_line_period_vc", vc_c, 1);
        if (k == 1 + 840) cmp("c_hsync_high", hs_c, 1);
    end

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            case (mode)
                0:       ce = 1'b1;
                1:       ce = (i % 4 == 0);
                default: ce = ($urandom_range(0, 2) != 0);
            endcase
        end
    endtask

    initial begin
        exp_t pin;
        pin = model(801, ma);
        cmp("model_line_wrap_vc", pin.vc, 1);
        pin = model(420001, ma);
        cmp("model_frame_period_fc", pin.fc, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_a_hc", hc_a, 799);
        cmp("rst_a_vc", vc_a, 524);
        cmp("rst_a_hsync", hs_a, 1);
        cmp("rst_a_de", de_a, 0);
        cmp("rst_c_hsync", hs_c, 0);
        #1 rst_n = 1'b1;

        @(posedge clk); #1 ce = 1'b1;
        @(posedge clk); #1 ce = 1'b0;
        @(negedge clk);
        cmp("first_hc", hc_a, 0);
        cmp("first_vc", vc_a, 0);
        cmp("first_de", de_a, 1);
        cmp("first_line_start", ls_a, 1);
        cmp("first_frame_start", fs_a, 1);
        cmp("first_frame_cnt", fc_a, 0);
        @(negedge clk);
        cmp("strobe_one_clk", ls_a, 0);
        cmp("hold_hc", hc_a, 0);

        run(2000, 0);
        run(800, 1);
        run(3000, 2);

        @(posedge clk);
        #3 rst_n = 1'b0;
        ce = 1'b1;
        #1;
        cmp("async_a_hc", hc_a, 799);
        cmp("async_a_vc", vc_a, 524);
        cmp("async_a_de", de_a, 0);
        cmp("async_a_fc", fc_a, 0);
        cmp("async_b_hc", hc_b, 14);
        cmp("async_b_vc", vc_b, 7);
        cmp("async_b_hsync", hs_b, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("rst_then_frame_start", fs_a, 1);
        cmp("rst_then_hc", hc_a, 0);

        run(1200, 2);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator; successor to the fixed 640x480 sync counter. Produces horizontal/vertical counters, sync pulses with selectable polarity, a data-enable, line/frame start strobes and a frame counter for any CEA/VESA-style mode. It advances on a pixel clock-enable, so it runs from a faster system clock. It sits between the clock tree and the pixel/sprite renderers; all outputs are registered and mutually aligned.

## Interface
- H_VISIBLE, 640: active pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync lengths in pixels
- V_VISIBLE, 480: active lines
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync lengths in lines
- HS_POL, 0 / VS_POL, 0: sync active level (0 = active-low)
- CNT_W, 12: counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- FRAME_W, 16: frame counter width
- PREFETCH, 2: prefetch lead in pixels (only used with VGA_TIMING_PREFETCH_EN)
- CLK  in  1  system clock; one clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel advance enable; tie high for a pixel-rate CLK
- hc  out  CNT_W  horizontal position, 0..H_TOTAL-1
- vc  out  CNT_W  vertical position, 0..V_TOTAL-1
- hsync / vsync  out  1  sync outputs at HS_POL/VS_POL active level
- de  out  1  high when hc < H_VISIBLE and vc < V_VISIBLE
- line_start  out  1  one-CLK strobe when hc becomes 0
- frame_start  out  1  one-CLK strobe when (hc,vc) becomes (0,0)
- frame_cnt  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is derived in the same way.
- On a CLK edge with pix_ce=1, hc increments. At hc = H_TOTAL-1, hc wraps to 0 and vc increments. At vc = V_TOTAL-1 with the hc wrap, vc wraps to 0 and frame_cnt increments.
- With pix_ce=0, all counters and level outputs hold. Strobes deassert.
- hsync is active for H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC. vsync is defined the same way on vc and changes only together with a vc change.
- hsync, vsync and de are computed from next-state counters and registered, so they are cycle-aligned with hc/vc (zero skew).
- line_start is asserted for exactly one CLK after a CE edge that loads hc=0. frame_start is asserted likewise for the edge that loads (0,0), together with line_start.
- Reset values: hc=H_TOTAL-1, vc=V_TOTAL-1, de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, frame_cnt=0.
  - The first pix_ce after reset therefore produces (0,0), de=1, line_start=1 and frame_start=1.
  - frame_cnt stays 0 on this first wrap, because no frame has completed.
- Reset asserted mid-frame returns all outputs to the reset values immediately (asynchronously), with no partial frame completion.
- frame_cnt wraps from 2^FRAME_W-1 to 0 silently.

## Timing
- Latency pix_ce → counter/output change: 1 CLK. There is no other pipeline.
- Line period: H_TOTAL pix_ce pulses. Frame period: H_TOTAL·V_TOTAL pix_ce pulses. Defaults give 800 and 420000.
- Strobes are single-CLK wide regardless of pix_ce duty.
- pix_ce may be irregular; output sequences are identical modulo stall cycles.

## Configuration
- VGA_TIMING_PREFETCH_EN defined: adds outputs fetch_x, fetch_y (CNT_W) and fetch_de (1).
  - These equal the hc, vc and de that will appear PREFETCH pix_ce pulses later, including wrap across line and frame boundaries.
  - They come from a second counter pair reset to the position PREFETCH pixels after the reset position.
  - They let memory-backed renderers absorb read latency.
- Not defined: these ports and the second counter pair do not exist. PREFETCH is ignored.

## Structure
- Package vga_timing_pkg:
  - mode constants for 640x480@60 (default) and 800x600@60;
  - a function computing H_TOTAL/V_TOTAL;
  - a function for reset position plus N pixels with wrap.
- Sub-module vga_axis_counter (limit, sync window, visible length; outputs count, wrap, sync, visible).
  - Instantiated for the horizontal and vertical axes.
  - Instantiated again for the prefetch pair.

## Test plan
- Reset, then pix_ce=1 for 1 CLK → hc=0, vc=0, de=1, line_start=1, frame_start=1, frame_cnt=0.
- Defaults, continuous CE → hsync low exactly for hc 656..751. vsync low exactly for vc 490..491. de high 640×480 pixels per frame. Frame period 420000 CLK.
- pix_ce = 1 every 4th CLK → same sequence at 4× period. Strobes stay 1 CLK wide. Outputs hold between CEs.
- HS_POL=1, VS_POL=1, 800x600 constants → sync high during windows. Line period 1056. frame_cnt=3 after 3 full frames.
- RST_N pulsed low at hc=300, vc=200 → outputs immediately at reset values. Next CE yields frame_start.
- VGA_TIMING_PREFETCH_EN, PREFETCH=2 → fetch_x/fetch_y/fetch_de equal hc/vc/de two CEs later, including across (799,524)→(0,0).
